// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin arbiter in front of a shared 7-bit add/sub unit with registered outputs
module adder_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [6:0] a0,
  input  logic [6:0] b0,
  input  logic       op0,
  input  logic       req1,
  input  logic [6:0] a1,
  input  logic [6:0] b1,
  input  logic       op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] result,
  output logic       done,
  output logic       done_id,
  output logic       busy,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic       last, last_nx;
  logic       sel, sel_nx;
  logic [6:0] ra, ra_nx, rb, rb_nx;
  logic       rop, rop_nx;
  logic       gnt0_nx, gnt1_nx, done_nx, done_id_nx, busy_nx;
  logic [7:0] result_nx, cnt0_nx, cnt1_nx;
  logic       grant, pick, exec;
  logic [6:0] bx, lo;
  logic [1:0] hi;
  assign grant = (state == IDLE) && (req0 || req1);
  assign pick  = (req0 && req1) ? ~last : req1;
  assign exec  = state == EXEC;
  // add/sub on captured operands; bit 6 is added separately so the carry into it is visible for overflow
  always_comb begin
    bx = rb ^ {7{rop}};
    lo = {1'b0, ra[5:0]} + {1'b0, bx[5:0]} + {6'b0, rop};
    hi = {1'b0, ra[6]} + {1'b0, bx[6]} + {1'b0, lo[6]};
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // next state: IDLE waits for any request, EXEC and DONE each last one cycle
  always_comb begin
    state_nx = state == IDLE ? (grant ? EXEC : IDLE) :
               state == EXEC ? DONE : IDLE;
  end
  // next values of every registered output and of the internal capture registers
  always_comb begin
    gnt0_nx    = (state_nx == IDLE) ? 1'b0 : grant ? ~pick : gnt0;
    gnt1_nx    = (state_nx == IDLE) ? 1'b0 : grant ?  pick : gnt1;
    done_nx    = exec;
    busy_nx    = state_nx != IDLE;
    result_nx  = exec ? {lo[6] ^ hi[1], hi[0], lo[5:0]} : result;
    done_id_nx = exec ? sel : done_id;
    cnt0_nx    = cnt0 + {7'b0, exec & ~sel};
    cnt1_nx    = cnt1 + {7'b0, exec &  sel};
    last_nx    = grant ? pick : last;
    sel_nx     = grant ? pick : sel;
    ra_nx      = grant ? (pick ? a1 : a0) : ra;
    rb_nx      = grant ? (pick ? b1 : b0) : rb;
    rop_nx     = grant ? (pick ? op1 : op0) : rop;
  end
  // output and capture registers; last=1 after reset so requester 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      result  <= 8'h00;
      done_id <= 1'b0;
      cnt0    <= 8'h00;
      cnt1    <= 8'h00;
      last    <= 1'b1;
      sel     <= 1'b0;
      ra      <= 7'h00;
      rb      <= 7'h00;
      rop     <= 1'b0;
    end else begin
      gnt0    <= gnt0_nx;
      gnt1    <= gnt1_nx;
      done    <= done_nx;
      busy    <= busy_nx;
      result  <= result_nx;
      done_id <= done_id_nx;
      cnt0    <= cnt0_nx;
      cnt1    <= cnt1_nx;
      last    <= last_nx;
      sel     <= sel_nx;
      ra      <= ra_nx;
      rb      <= rb_nx;
      rop     <= rop_nx;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed table-driven bench for adder_arbiter
module tb_adder_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, req0, req1, op0, op1;
  logic [6:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done, done_id, busy;
  logic [7:0] result, cnt0, cnt1;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] ec0, ec1;
  typedef struct {
    logic       id;
    logic [6:0] a;
    logic [6:0] b;
    logic       op;
    logic [7:0] res;
  } vec_t;
  vec_t vecs[7];

  adder_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .result(result), .done(done),
    .done_id(done_id), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [6:0] a, input logic [6:0] b, input logic op);
    if (id) begin req1 = v; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = v; a0 = a; b0 = b; op0 = op; end
  endtask

  task automatic bump(input logic id);
    if (id) ec1 = ec1 + 8'd1;
    else    ec0 = ec0 + 8'd1;
  endtask

  task automatic run_op(input string name, input logic id, input logic [6:0] a, input logic [6:0] b, input logic op, input logic [7:0] res);
    set_req(id, 1'b1, a, b, op);
    tick();
    chk({name, " gnt0 e0"}, gnt0, !id);
    chk({name, " gnt1 e0"}, gnt1, id);
    chk({name, " busy e0"}, busy, 1);
    chk({name, " done e0"}, done, 0);
    tick();
    bump(id);
    chk({name, " done e1"}, done, 1);
    chk({name, " result"}, result, res);
    chk({name, " done_id"}, done_id, id);
    chk({name, " cnt0"}, cnt0, ec0);
    chk({name, " cnt1"}, cnt1, ec1);
    req0 = 0;
    req1 = 0;
    tick();
    chk({name, " gnt e2"}, {gnt0, gnt1}, 0);
    chk({name, " done e2"}, done, 0);
    chk({name, " busy e2"}, busy, 0);
    chk({name, " result held"}, result, res);
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'h05, 7'h03, 1'b0, 8'h08};
    vecs[1] = '{1'b1, 7'h10, 7'h20, 1'b1, 8'h70};
    vecs[2] = '{1'b0, 7'h3F, 7'h01, 1'b0, 8'hC0};
    vecs[3] = '{1'b0, 7'h40, 7'h01, 1'b1, 8'hBF};
    vecs[4] = '{1'b1, 7'h7F, 7'h7F, 1'b0, 8'h7E};
    vecs[5] = '{1'b1, 7'h40, 7'h40, 1'b0, 8'h80};
    vecs[6] = '{1'b0, 7'h00, 7'h01, 1'b1, 8'h7F};
    rst_n = 0; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    ec0 = 0; ec1 = 0;
    tick();
    tick();
    chk("rst gnt0", gnt0, 0);
    chk("rst gnt1", gnt1, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst result", result, 8'h00);
    chk("rst done_id", done_id, 0);
    chk("rst cnt0", cnt0, 0);
    chk("rst cnt1", cnt1, 0);
    rst_n = 1;
    tick();
    chk("idle busy", busy, 0);
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res);

    rst_n = 0;
    tick();
    set_req(0, 1, 7'h01, 7'h01, 0);
    set_req(1, 1, 7'h0A, 7'h03, 1);
    tick();
    chk("rr reset ignores req", {gnt0, gnt1, busy}, 0);
    ec0 = 0; ec1 = 0;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d gnt0", k), gnt0, (k % 2) == 0);
      chk($sformatf("rr%0d gnt1", k), gnt1, (k % 2) == 1);
      tick();
      bump(k % 2 == 1);
      chk($sformatf("rr%0d done", k), done, 1);
      chk($sformatf("rr%0d done_id", k), done_id, k % 2 == 1);
      chk($sformatf("rr%0d result", k), result, (k % 2) ? 8'h07 : 8'h02);
      chk($sformatf("rr%0d cnt0", k), cnt0, ec0);
      chk($sformatf("rr%0d cnt1", k), cnt1, ec1);
      if (k == 3) begin req0 = 0; req1 = 0; end
      tick();
      chk($sformatf("rr%0d done low", k), done, 0);
    end
    tick();
    chk("rr idle after drop", busy, 0);

    set_req(0, 1, 7'h05, 7'h03, 0);
    tick();
    chk("mid gnt0", gnt0, 1);
    rst_n = 0;
    req0 = 0;
    tick();
    chk("mid done", done, 0);
    chk("mid busy", busy, 0);
    chk("mid gnt0 cleared", gnt0, 0);
    chk("mid cnt0", cnt0, 0);
    chk("mid result", result, 8'h00);
    rst_n = 1;
    ec0 = 0; ec1 = 0;
    tick();
    chk("mid no late done", done, 0);

    set_req(0, 1, 7'h11, 7'h22, 0);
    tick();
    set_req(0, 1, 7'h7F, 7'h7F, 1);
    tick();
    ec0 = ec0 + 8'd1;
    chk("capture done", done, 1);
    chk("capture result", result, 8'h33);
    chk("capture cnt0", cnt0, ec0);
    req0 = 0;
    tick();

    set_req(1, 1, 7'h02, 7'h05, 1);
    tick();
    req1 = 0;
    tick();
    ec1 = ec1 + 8'd1;
    chk("drop done", done, 1);
    chk("drop result", result, 8'h7D);
    chk("drop cnt1", cnt1, ec1);
    tick();
    chk("drop idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
